// File: rtl/fpga_cfg_pkg.sv
// Shared sizing, frame constants, loader state encoding and the header check.
package fpga_cfg_pkg;

    localparam int N_LUT  = 9;
    localparam int LUT_W  = 33;
    localparam int N_SB   = 13;
    localparam int SB_W   = 16;
    localparam int WORD_W = 32;
    localparam int NWORDS = 2 * N_LUT + N_SB;
    localparam int IDX_W  = $clog2(NWORDS);
    localparam logic [15:0] MAGIC = 16'hF9C0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        COMMIT,
        DONE,
        ERR
    } state_t;

    function automatic logic hdr_valid(input logic [WORD_W-1:0] w);
        return (w[31:16] == MAGIC) && (w[15:0] == 16'(NWORDS));
    endfunction

endpackage

// File: rtl/fpga_cfg_loader.sv
// Unpacks a framed word stream into shadow regs; commits to fabric one cycle after a good checksum.
// Stalls freely on cfg_valid low; cfg_ready drops only during the single COMMIT cycle.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [WORD_W-1:0]        cfg_data,
    output logic [N_LUT*LUT_W-1:0]   lut_cfg,
    output logic [N_SB*SB_W-1:0]     sb_cfg,
    output logic                     fabric_en,
    output logic                     cfg_done,
    output logic                     cfg_err
);

    localparam int LB_W = $clog2(N_LUT * LUT_W);
    localparam int SB_BW = $clog2(N_SB * SB_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [IDX_W-1:0] SB_START = IDX_W'(2 * N_LUT);

    state_t                    r_state;
    logic [IDX_W-1:0]          r_idx;
    logic [WORD_W-1:0]         r_xor;
    logic [N_LUT*LUT_W-1:0]    r_shd_lut;
    logic [N_SB*SB_W-1:0]      r_shd_sb;

    logic                      w_xfer;
    logic                      w_hdr_ok;
    logic [IDX_W-1:0]          w_sb_idx;
    logic [LB_W-1:0]           w_lut_base;
    logic [SB_BW-1:0]          w_sb_base;

    assign cfg_ready  = (r_state != COMMIT);
    assign fabric_en  = cfg_done;
    assign w_xfer     = cfg_valid && cfg_ready;
    assign w_hdr_ok   = hdr_valid(cfg_data);
    // Even/odd word pairs share one LUT slot; SB base is only meaningful once idx >= SB_START.
    assign w_sb_idx   = r_idx - SB_START;
    assign w_lut_base = LB_W'(r_idx[IDX_W-1:1]) * LB_W'(LUT_W);
    assign w_sb_base  = SB_BW'(w_sb_idx) * SB_BW'(SB_W);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_xor     <= '0;
            r_shd_lut <= '0;
            r_shd_sb  <= '0;
            lut_cfg   <= '0;
            sb_cfg    <= '0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (w_xfer) begin
                        cfg_done <= 1'b0;
                        if (w_hdr_ok) begin
                            r_state <= LOAD;
                            r_idx   <= '0;
                            r_xor   <= '0;
                            cfg_err <= 1'b0;
                        end else begin
                            r_state <= ERR;
                            cfg_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_xfer) begin
                        if (r_idx < SB_START) begin
                            if (!r_idx[0])
                                r_shd_lut[w_lut_base +: WORD_W] <= cfg_data;
                            else
                                r_shd_lut[w_lut_base + LB_W'(WORD_W)] <= cfg_data[0];
                        end else begin
                            r_shd_sb[w_sb_base +: SB_W] <= cfg_data[SB_W-1:0];
                        end
                        r_xor <= r_xor ^ cfg_data;
                        r_idx <= r_idx + IDX_W'(1);
                        if (r_idx == LAST_IDX)
                            r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_xfer) begin
                        if (cfg_data == r_xor) begin
                            r_state <= COMMIT;
                        end else begin
                            r_state <= ERR;
                            cfg_err <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    lut_cfg  <= r_shd_lut;
                    sb_cfg   <= r_shd_sb;
                    cfg_done <= 1'b1;
                    r_state  <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
